// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: index widths,
// counter default width, memory-wait FSM encodings and the control bundle.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned REG_IDX_W = 5;
    localparam int unsigned CNT_W_DEF = 32;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_RESP = 2'd2
    } mem_state_e;

    typedef struct packed {
        logic stall_if;
        logic stall_id;
        logic stall_ex;
        logic stall_ls;
        logic bubble_ex;
        logic bubble_ls;
        logic flush_id;
        logic redirect_fire;
    } hazard_ctl_t;

    function automatic logic src_hit(
        input logic                 used,
        input logic [REG_IDX_W-1:0] rs_idx,
        input logic [REG_IDX_W-1:0] rd_idx
    );
        return used && (rs_idx == rd_idx);
    endfunction

endpackage

// File: rtl/mem_wait_fsm.sv
// Tracks an outstanding data-memory request from LS through its response,
// raising mem_stall while waiting and a sticky flag on stray response strobes.
module mem_wait_fsm
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ls_req_valid,
    input  logic       ls_req_ready,
    input  logic       ls_resp_valid,
    output logic [1:0] mem_state,
    output logic       mem_stall,
    output logic       proto_err
);

    mem_state_e state_q, state_d;
    logic       proto_err_q, proto_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= MEM_IDLE;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_stall   = 1'b0;
        proto_err_d = proto_err_q;
        case (state_q)
            MEM_REQ: begin
                mem_stall = 1'b1;
                if (ls_req_ready) state_d = MEM_RESP;
                if (ls_resp_valid) proto_err_d = 1'b1;
            end
            MEM_RESP: begin
                mem_stall = ~ls_resp_valid;
                if (ls_resp_valid) state_d = MEM_IDLE;
            end
            default: begin
                // Also covers the unused encoding, which recovers like IDLE.
                state_d   = MEM_IDLE;
                mem_stall = ls_req_valid;
                if (ls_req_valid) state_d = ls_req_ready ? MEM_RESP : MEM_REQ;
                if (ls_resp_valid) proto_err_d = 1'b1;
            end
        endcase
    end

    assign mem_state = state_q;
    assign proto_err = proto_err_q;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: prioritises memory wait, MDU busy, redirect and
// load-use hazards into stall/bubble/flush controls, plus performance counters.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [REG_IDX_W-1:0] rs1_id_idx,
    input  logic [REG_IDX_W-1:0] rs2_id_idx,
    input  logic                 rs1_used,
    input  logic                 rs2_used,
    input  logic [REG_IDX_W-1:0] ex_rd_idx,
    input  logic                 ex_wben,
    input  logic                 ex_is_load,
    input  logic                 ex_redirect,
    input  logic                 mdu_busy,
    input  logic                 ls_req_valid,
    input  logic                 ls_req_ready,
    input  logic                 ls_resp_valid,
    input  logic                 cnt_clr,
    output logic                 stall_if,
    output logic                 stall_id,
    output logic                 stall_ex,
    output logic                 stall_ls,
    output logic                 bubble_ex,
    output logic                 bubble_ls,
    output logic                 flush_id,
    output logic                 redirect_fire,
    output logic [1:0]           mem_state,
    output logic                 proto_err,
    output logic [CNT_W-1:0]     stall_cnt,
    output logic [CNT_W-1:0]     redirect_cnt
);

    logic        mem_stall;
    logic        load_use;
    hazard_ctl_t ctl;

    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;

    mem_wait_fsm u_mem_wait_fsm (
        .clk           (clk),
        .rst_n         (rst_n),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_resp_valid (ls_resp_valid),
        .mem_state     (mem_state),
        .mem_stall     (mem_stall),
        .proto_err     (proto_err)
    );

    always_comb begin
        load_use = ex_is_load && ex_wben && (ex_rd_idx != '0) &&
                   (src_hit(rs1_used, rs1_id_idx, ex_rd_idx) ||
                    src_hit(rs2_used, rs2_id_idx, ex_rd_idx));
    end

    // Strict priority: only the highest active hazard shapes the controls.
    always_comb begin
        ctl = '0;
        if (mem_stall) begin
            ctl.stall_if = 1'b1;
            ctl.stall_id = 1'b1;
            ctl.stall_ex = 1'b1;
            ctl.stall_ls = 1'b1;
        end else if (mdu_busy) begin
            ctl.stall_if  = 1'b1;
            ctl.stall_id  = 1'b1;
            ctl.stall_ex  = 1'b1;
            ctl.bubble_ls = 1'b1;
        end else if (ex_redirect) begin
            ctl.redirect_fire = 1'b1;
            ctl.flush_id      = 1'b1;
            ctl.bubble_ex     = 1'b1;
        end else if (load_use) begin
            ctl.stall_if  = 1'b1;
            ctl.stall_id  = 1'b1;
            ctl.bubble_ex = 1'b1;
        end
    end

    assign stall_if      = ctl.stall_if;
    assign stall_id      = ctl.stall_id;
    assign stall_ex      = ctl.stall_ex;
    assign stall_ls      = ctl.stall_ls;
    assign bubble_ex     = ctl.bubble_ex;
    assign bubble_ls     = ctl.bubble_ls;
    assign flush_id      = ctl.flush_id;
    assign redirect_fire = ctl.redirect_fire;

    always_comb begin
        stall_cnt_d    = stall_cnt_q;
        redirect_cnt_d = redirect_cnt_q;
        if (cnt_clr) begin
            stall_cnt_d    = '0;
            redirect_cnt_d = '0;
        end else begin
            if (ctl.stall_if)      stall_cnt_d    = stall_cnt_q + CNT_W'(1);
            if (ctl.redirect_fire) redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q    <= '0;
            redirect_cnt_q <= '0;
        end else begin
            stall_cnt_q    <= stall_cnt_d;
            redirect_cnt_q <= redirect_cnt_d;
        end
    end

    assign stall_cnt    = stall_cnt_q;
    assign redirect_cnt = redirect_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: expected controls are queued as
// stimulus is applied and compared with captured outputs per scenario.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW = 4;

    localparam logic [7:0] E_NONE  = 8'h00;
    localparam logic [7:0] E_MEM   = 8'hF0;
    localparam logic [7:0] E_MDU   = 8'hE4;
    localparam logic [7:0] E_REDIR = 8'h0B;
    localparam logic [7:0] E_LU    = 8'hC8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [4:0]    rs1_id_idx, rs2_id_idx, ex_rd_idx;
    logic          rs1_used, rs2_used, ex_wben, ex_is_load, ex_redirect, mdu_busy;
    logic          ls_req_valid, ls_req_ready, ls_resp_valid, cnt_clr;
    logic          stall_if, stall_id, stall_ex, stall_ls;
    logic          bubble_ex, bubble_ls, flush_id, redirect_fire, proto_err;
    logic [1:0]    mem_state;
    logic [CW-1:0] stall_cnt, redirect_cnt;

    logic [10:0]   exp_q[$];
    logic [10:0]   obs_q[$];
    logic [CW-1:0] m_stall, m_redir;
    logic          m_perr;
    int            n_chk, n_pass;

    pipe_hazard_ctrl #(.CNT_W(CW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .rs1_id_idx    (rs1_id_idx),
        .rs2_id_idx    (rs2_id_idx),
        .rs1_used      (rs1_used),
        .rs2_used      (rs2_used),
        .ex_rd_idx     (ex_rd_idx),
        .ex_wben       (ex_wben),
        .ex_is_load    (ex_is_load),
        .ex_redirect   (ex_redirect),
        .mdu_busy      (mdu_busy),
        .ls_req_valid  (ls_req_valid),
        .ls_req_ready  (ls_req_ready),
        .ls_resp_valid (ls_resp_valid),
        .cnt_clr       (cnt_clr),
        .stall_if      (stall_if),
        .stall_id      (stall_id),
        .stall_ex      (stall_ex),
        .stall_ls      (stall_ls),
        .bubble_ex     (bubble_ex),
        .bubble_ls     (bubble_ls),
        .flush_id      (flush_id),
        .redirect_fire (redirect_fire),
        .mem_state     (mem_state),
        .proto_err     (proto_err),
        .stall_cnt     (stall_cnt),
        .redirect_cnt  (redirect_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got hang want finish");
        $fatal(1);
    end

    function automatic logic [10:0] outs();
        return {stall_if, stall_id, stall_ex, stall_ls, bubble_ex, bubble_ls,
                flush_id, redirect_fire, mem_state, proto_err};
    endfunction

    task automatic idle();
        rs1_id_idx = '0; rs2_id_idx = '0; ex_rd_idx = '0;
        rs1_used = 0; rs2_used = 0; ex_wben = 0; ex_is_load = 0;
        ex_redirect = 0; mdu_busy = 0;
        ls_req_valid = 0; ls_req_ready = 0; ls_resp_valid = 0; cnt_clr = 0;
    endtask

    // Queue the expected outputs for the inputs now applied, capture the DUT
    // mid-cycle, then advance the counter/flag model across the clock edge.
    task automatic cyc(input logic [7:0] ctl, input logic [1:0] ms);
        exp_q.push_back({ctl, ms, m_perr});
        @(negedge clk);
        obs_q.push_back(outs());
        if (cnt_clr) begin
            m_stall = '0;
            m_redir = '0;
        end else begin
            if (ctl[7]) m_stall = m_stall + 1'b1;
            if (ctl[0]) m_redir = m_redir + 1'b1;
        end
        if (ls_resp_valid && ms != 2'd2) m_perr = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_n = 0;
        m_stall = '0; m_redir = '0; m_perr = 0;
        #3;
        n_chk++;
        if (outs() !== 11'd0 || stall_cnt !== 4'd0 || redirect_cnt !== 4'd0)
            $display("FAIL reset_state: got outs=%b cnt=%0d/%0d want 0 0/0", outs(), stall_cnt, redirect_cnt);
        else n_pass++;
        #9 rst_n = 1;
        @(posedge clk); #1;
        cyc(E_NONE, 2'd0);
        cyc(E_NONE, 2'd0);
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL reset_idle: got %b want %b", g, w);
            else n_pass++;
        end
    endtask

    task automatic test_load_use();
        idle();
        ex_is_load = 1; ex_wben = 1; ex_rd_idx = 5; rs2_id_idx = 5; rs2_used = 1;
        cyc(E_LU, 2'd0);
        ex_is_load = 0; ex_wben = 0;
        cyc(E_NONE, 2'd0);
        ex_is_load = 1; ex_wben = 1; ex_rd_idx = 0; rs2_id_idx = 0;
        cyc(E_NONE, 2'd0);
        ex_rd_idx = 9; rs2_id_idx = 3; rs1_id_idx = 9; rs1_used = 0;
        cyc(E_NONE, 2'd0);
        rs1_used = 1;
        cyc(E_LU, 2'd0);
        ex_wben = 0;
        cyc(E_NONE, 2'd0);
        ex_wben = 1; ex_is_load = 0;
        cyc(E_NONE, 2'd0);
        idle();
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL load_use: got %b want %b", g, w);
            else n_pass++;
        end
        n_chk++;
        if (stall_cnt !== m_stall) $display("FAIL load_use_cnt: got %0d want %0d", stall_cnt, m_stall);
        else n_pass++;
    endtask

    task automatic test_mem_wait();
        idle();
        cnt_clr = 1;
        cyc(E_NONE, 2'd0);
        cnt_clr = 0;
        ls_req_valid = 1;
        cyc(E_MEM, 2'd0);
        cyc(E_MEM, 2'd1);
        cyc(E_MEM, 2'd1);
        ls_req_ready = 1;
        cyc(E_MEM, 2'd1);
        ls_req_ready = 0;
        cyc(E_MEM, 2'd2);
        ls_resp_valid = 1;
        cyc(E_NONE, 2'd2);
        // Requester keeps valid high, so the returning IDLE cycle stalls too.
        ls_resp_valid = 0;
        cyc(E_MEM, 2'd0);
        n_chk++;
        if (stall_cnt !== 4'd6 || m_stall !== 4'd6)
            $display("FAIL mem_wait_cnt: got %0d want 6 (model %0d)", stall_cnt, m_stall);
        else n_pass++;
        ls_req_ready = 1;
        cyc(E_MEM, 2'd1);
        ls_req_valid = 0; ls_req_ready = 0;
        cyc(E_MEM, 2'd2);
        ls_resp_valid = 1;
        cyc(E_NONE, 2'd2);
        ls_resp_valid = 0;
        cyc(E_NONE, 2'd0);
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL mem_wait: got %b want %b", g, w);
            else n_pass++;
        end
    endtask

    task automatic test_redirect();
        idle();
        cnt_clr = 1;
        cyc(E_NONE, 2'd0);
        cnt_clr = 0;
        ex_is_load = 1; ex_wben = 1; ex_rd_idx = 7; rs1_id_idx = 7; rs1_used = 1;
        ex_redirect = 1;
        cyc(E_REDIR, 2'd0);
        idle();
        cyc(E_NONE, 2'd0);
        n_chk++;
        if (redirect_cnt !== 4'd1) $display("FAIL redirect_cnt: got %0d want 1", redirect_cnt);
        else n_pass++;
        ex_redirect = 1; ls_req_valid = 1; ls_req_ready = 1;
        cyc(E_MEM, 2'd0);
        ls_req_valid = 0; ls_req_ready = 0; ls_resp_valid = 1;
        cyc(E_REDIR, 2'd2);
        idle();
        cyc(E_NONE, 2'd0);
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL redirect: got %b want %b", g, w);
            else n_pass++;
        end
        n_chk++;
        if (redirect_cnt !== m_redir) $display("FAIL redirect_cnt2: got %0d want %0d", redirect_cnt, m_redir);
        else n_pass++;
    endtask

    task automatic test_mdu_hold();
        idle();
        ex_redirect = 1; mdu_busy = 1;
        for (int i = 0; i < 4; i++) cyc(E_MDU, 2'd0);
        mdu_busy = 0;
        cyc(E_REDIR, 2'd0);
        ex_redirect = 0; mdu_busy = 1;
        ex_is_load = 1; ex_wben = 1; ex_rd_idx = 12; rs2_id_idx = 12; rs2_used = 1;
        cyc(E_MDU, 2'd0);
        mdu_busy = 0;
        cyc(E_LU, 2'd0);
        idle();
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL mdu_hold: got %b want %b", g, w);
            else n_pass++;
        end
        n_chk++;
        if (stall_cnt !== m_stall || redirect_cnt !== m_redir)
            $display("FAIL mdu_cnt: got %0d/%0d want %0d/%0d", stall_cnt, redirect_cnt, m_stall, m_redir);
        else n_pass++;
    endtask

    task automatic test_cnt_wrap();
        idle();
        cnt_clr = 1;
        cyc(E_NONE, 2'd0);
        cnt_clr = 0; mdu_busy = 1;
        for (int i = 0; i < 15; i++) cyc(E_MDU, 2'd0);
        n_chk++;
        if (stall_cnt !== 4'hF) $display("FAIL cnt_preload: got %0d want 15", stall_cnt);
        else n_pass++;
        cyc(E_MDU, 2'd0);
        n_chk++;
        if (stall_cnt !== 4'd0 || m_stall !== 4'd0) $display("FAIL cnt_wrap: got %0d want 0", stall_cnt);
        else n_pass++;
        for (int i = 0; i < 3; i++) cyc(E_MDU, 2'd0);
        cnt_clr = 1;
        cyc(E_MDU, 2'd0);
        cnt_clr = 0; mdu_busy = 0;
        n_chk++;
        if (stall_cnt !== 4'd0) $display("FAIL cnt_clr_prio: got %0d want 0", stall_cnt);
        else n_pass++;
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL cnt_wrap_ctl: got %b want %b", g, w);
            else n_pass++;
        end
    endtask

    task automatic test_proto_reset();
        idle();
        mdu_busy = 1;
        cyc(E_MDU, 2'd0);
        ex_redirect = 1; mdu_busy = 0;
        cyc(E_REDIR, 2'd0);
        idle();
        ls_resp_valid = 1;
        cyc(E_NONE, 2'd0);
        ls_resp_valid = 0;
        cyc(E_NONE, 2'd0);
        cyc(E_NONE, 2'd0);
        ls_req_valid = 1; ls_req_ready = 1;
        cyc(E_MEM, 2'd0);
        ls_req_valid = 0; ls_req_ready = 0;
        cyc(E_MEM, 2'd2);
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL proto_err: got %b want %b", g, w);
            else n_pass++;
        end
        n_chk++;
        if (mem_state !== 2'd2 || stall_cnt === 4'd0 || redirect_cnt === 4'd0)
            $display("FAIL pre_reset: got state=%0d cnt=%0d/%0d want 2 nonzero", mem_state, stall_cnt, redirect_cnt);
        else n_pass++;
        rst_n = 0;
        m_stall = '0; m_redir = '0; m_perr = 0;
        #2;
        n_chk++;
        if (mem_state !== 2'd0 || proto_err !== 1'b0 || stall_cnt !== 4'd0 || redirect_cnt !== 4'd0)
            $display("FAIL async_reset: got state=%0d perr=%b cnt=%0d/%0d want 0 0 0/0",
                     mem_state, proto_err, stall_cnt, redirect_cnt);
        else n_pass++;
        #1 rst_n = 1;
        @(posedge clk); #1;
        cyc(E_NONE, 2'd0);
        cyc(E_NONE, 2'd0);
        while (exp_q.size() > 0) begin
            logic [10:0] w, g;
            w = exp_q.pop_front(); g = obs_q.pop_front(); n_chk++;
            if (g !== w) $display("FAIL post_reset: got %b want %b", g, w);
            else n_pass++;
        end
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_mdu_hold();
        test_cnt_wrap();
        test_proto_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of both performance counters.
REQ-002 clk  in  1  pipeline clock, all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 rs1_id_idx, rs2_id_idx  in  5 each  source register indices of the instruction in ID.
REQ-005 rs1_used, rs2_used  in  1 each  ID instruction actually reads rs1/rs2.
REQ-006 ex_rd_idx  in  5  destination index of the instruction in EX.
REQ-007 ex_wben, ex_is_load  in  1 each  EX instruction writes rd / is a load.
REQ-008 ex_redirect  in  1  EX resolved taken jump/branch mispredict.
REQ-009 mdu_busy  in  1  multi-cycle mul/div unit in EX not finished.
REQ-010 ls_req_valid, ls_req_ready  in  1 each  LS-stage data-memory request handshake.
REQ-011 ls_resp_valid  in  1  data-memory response strobe.
REQ-012 cnt_clr  in  1  synchronous clear of both counters.
REQ-013 stall_if, stall_id, stall_ex, stall_ls  out  1 each  hold the stage's pipeline register.
REQ-014 bubble_ex, bubble_ls  out  1 each  load a NOP into the EX / LS pipeline register.
REQ-015 flush_id  out  1  kill the instructions in IF and ID.
REQ-016 redirect_fire  out  1  PC redirect accepted this cycle.
REQ-017 mem_state  out  2  current memory-wait FSM state.
REQ-018 proto_err  out  1  sticky memory-protocol violation flag.
REQ-019 stall_cnt, redirect_cnt  out  CNT_W each  performance counters.

Function
REQ-020 load_use = ex_is_load & ex_wben & (ex_rd_idx != 0) & ((rs1_used & rs1_id_idx == ex_rd_idx) | (rs2_used & rs2_id_idx == ex_rd_idx)), combinational.
REQ-021 FSM states IDLE=0, REQ=1, RESP=2; encoding 3 unused and treated as IDLE.
REQ-022 IDLE: ls_req_valid & ls_req_ready -> RESP; ls_req_valid & ~ls_req_ready -> REQ; otherwise stay.
REQ-023 REQ: ls_req_ready -> RESP; otherwise stay.
REQ-024 RESP: ls_resp_valid -> IDLE; otherwise stay; response is never accepted in the acceptance cycle (minimum 1-cycle latency).
REQ-025 mem_stall = (IDLE & ls_req_valid) | REQ | (RESP & ~ls_resp_valid), combinational.
REQ-026 Priority is mem_stall > mdu_busy > ex_redirect > load_use; only the highest active condition drives the outputs.
REQ-027 mem_stall: all four stall_* = 1; bubbles, flush_id and redirect_fire = 0.
REQ-028 mdu_busy: stall_if/id/ex = 1, bubble_ls = 1, stall_ls = 0; redirect held pending.
REQ-029 ex_redirect: redirect_fire = 1, flush_id = 1, bubble_ex = 1, no stall; a coincident load_use is discarded.
REQ-030 load_use: stall_if = stall_id = 1, bubble_ex = 1; exactly one bubble per load, because the load leaves EX in the next cycle.
REQ-031 No condition active: all stall/bubble/flush outputs = 0.
REQ-032 ls_resp_valid in IDLE or REQ sets proto_err, which clears only on reset; the FSM ignores the strobe.
REQ-033 stall_cnt increments on every cycle with stall_if = 1; redirect_cnt increments on every redirect_fire.
REQ-034 Both counters wrap modulo 2^CNT_W; cnt_clr has priority over increment.
REQ-035 Outputs are combinational from the current state and inputs; no added latency.

Reset
REQ-036 Asserting rst_n low immediately forces FSM to IDLE, proto_err = 0 and both counters = 0.
REQ-037 An outstanding memory response during reset is dropped; with inputs idle after reset, all stall/bubble/flush/redirect outputs = 0.

Structure
REQ-038 Register-index width (5), FSM state encodings and CNT_W default live in the shared defines file.
REQ-039 The memory-wait FSM is one sub-module, mem_wait_fsm, which outputs mem_state, mem_stall and proto_err; counters and the priority mux stay in the top level.

Verification
REQ-040 ex_is_load = 1, ex_wben = 1, ex_rd_idx = 5, rs2_id_idx = 5, rs2_used = 1 -> one cycle of stall_if = stall_id = bubble_ex = 1; same stimulus with ex_rd_idx = 0 -> no stall.
REQ-041 ls_req_valid with ready low 3 cycles, then ready, then resp after 2 cycles -> mem_state 0,1,1,1,2,2,0; all stall_* high for 6 cycles; stall_cnt = 6.
REQ-042 ex_redirect and load_use in the same cycle -> redirect_fire = flush_id = bubble_ex = 1, stall_if = 0; redirect_cnt = 1.
REQ-043 ex_redirect with mdu_busy for 4 cycles -> redirect_fire = 0 for 4 cycles, then 1 in the cycle mdu_busy drops.
REQ-044 ls_resp_valid pulsed in IDLE -> proto_err = 1 and stays 1; rst_n pulsed while in RESP -> mem_state = 0, proto_err = 0, counters = 0.
REQ-045 Preload stall_cnt to 2^CNT_W-1, stall one cycle -> stall_cnt = 0; cnt_clr together with a stall -> stall_cnt = 0.
